// File: rtl/clk_div_pkg.sv
// Shared constants, types and helpers for the programmable clock divider.
package clk_div_pkg;

    localparam int MIN_DIV   = 2;
    localparam int DEF_CNT_W = 16;

    typedef logic [DEF_CNT_W-1:0] div_t;

    // Uses a 33-bit sum so that D+1 cannot wrap for any divisor up to 32 bits wide.
    function automatic logic [31:0] half_hi(input logic [31:0] d);
        logic [32:0] sum;
        sum = {1'b0, d} + 33'd1;
        return sum[32:1];
    endfunction

endpackage

// File: rtl/clk_div_odd_stage.sv
// Negedge retiming flop and even/odd output select for the divided clock.
module clk_div_odd_stage (
    input  logic clk,
    input  logic reset,
    input  logic pos_q,
    input  logic is_odd,
    output logic clk_out
);

    logic neg_q;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset)
            neg_q <= 1'b0;
        else
            neg_q <= pos_q;
    end

    // ANDing with the half-cycle-delayed copy trims an odd-length high phase to D/2 cycles.
    assign clk_out = is_odd ? (pos_q & neg_q) : pos_q;

endmodule

// File: rtl/prog_clk_divider.sv
// Runtime-programmable integer clock divider with 50% duty output, period tick and config handshake.
module prog_clk_divider
    import clk_div_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int RESET_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic [CNT_W-1:0] div_active,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(RESET_DIV);
    localparam logic [CNT_W-1:0] RST_CNT = RST_DIV - 1'b1;
    localparam logic [CNT_W-1:0] MIN_D   = CNT_W'(MIN_DIV);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] pending;
    logic [CNT_W-1:0] div_next;
    logic [CNT_W-1:0] half;
    logic             pos_q;
    logic             wrap;
    logic             apply;
    logic             offer;

    // A pending divisor exists exactly when cfg_ready is low, so it is swapped in on the next wrap.
    always_comb begin
        wrap     = (cnt == div_active - 1'b1);
        apply    = en && wrap && !cfg_ready;
        div_next = apply ? pending : div_active;
        half     = CNT_W'(half_hi(32'(div_next)));
        offer    = cfg_valid && cfg_ready;
        cnt_next = cnt;
        if (en)
            cnt_next = wrap ? '0 : cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= RST_CNT;
            div_active <= RST_DIV;
            pending    <= RST_DIV;
            pos_q      <= 1'b0;
            tick       <= 1'b0;
            cfg_ready  <= 1'b1;
            cfg_err    <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            div_active <= div_next;
            tick       <= en && (cnt_next == '0);
            cfg_err    <= offer && (cfg_div < MIN_D);
            if (en)
                pos_q <= (cnt_next < half);
            if (offer && (cfg_div >= MIN_D)) begin
                pending   <= cfg_div;
                cfg_ready <= 1'b0;
            end else if (apply) begin
                cfg_ready <= 1'b1;
            end
        end
    end

    clk_div_odd_stage u_odd_stage (
        .clk     (clk),
        .reset   (reset),
        .pos_q   (pos_q),
        .is_odd  (div_active[0]),
        .clk_out (clk_out)
    );

endmodule

// File: tb/tb_prog_clk_divider.sv
// Randomized, model-checked testbench for prog_clk_divider.
module tb_prog_clk_divider;
    import clk_div_pkg::*;

    logic clk;
    logic reset;
    logic en;
    logic cfg_valid;
    div_t cfg_div;
    logic cfg_ready;
    logic cfg_err;
    div_t div_active;
    logic clk_out;
    logic tick;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: position in period, divisor in force, pending offer
    int m_d, m_k, m_pend;
    bit m_pend_v, m_ready, m_err, m_tick, m_last_en;

    // Samples taken after each posedge and negedge
    logic a_out_p, a_out_n, a_tick, a_ready, a_err;
    div_t a_div;
    logic e_out_p, e_out_n;

    time t_rise = 0, t_prev_rise = 0, t_high = 0;

    prog_clk_divider #(.CNT_W(16), .RESET_DIV(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .cfg_err    (cfg_err),
        .div_active (div_active),
        .clk_out    (clk_out),
        .tick       (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk_out) begin
        t_prev_rise = t_rise;
        t_rise      = $time;
    end
    always @(negedge clk_out) t_high = $time - t_rise;

    // clk_out is high for D half-cycles per period; odd D starts half a cycle after the wrap edge.
    function automatic logic exp_out(int d, int h);
        if (d % 2 == 1) return (h >= 1) && (h <= d);
        return h < d;
    endfunction

    task automatic model_reset();
        m_d = 2; m_k = 1; m_pend = 0;
        m_pend_v = 0; m_ready = 1; m_err = 0; m_tick = 0; m_last_en = 1;
    endtask

    task automatic model_edge();
        bit wrapped, applied;
        wrapped = 0; applied = 0;
        if (en) begin
            if (m_k == m_d - 1) begin
                m_k = 0; wrapped = 1;
                if (m_pend_v) begin m_d = m_pend; m_pend_v = 0; applied = 1; end
            end else begin
                m_k++;
            end
        end
        m_err = 0;
        if (cfg_valid && m_ready) begin
            if (int'(cfg_div) >= 2) begin m_pend = int'(cfg_div); m_pend_v = 1; m_ready = 0; end
            else m_err = 1;
        end
        if (applied) m_ready = 1;
        m_tick = en && wrapped;
        m_last_en = en;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        a_out_p = clk_out; a_tick = tick; a_ready = cfg_ready; a_err = cfg_err; a_div = div_active;
        e_out_p = exp_out(m_d, m_last_en ? 2 * m_k : 2 * m_k + 1);
        @(negedge clk);
        #1;
        a_out_n = clk_out;
        e_out_n = exp_out(m_d, 2 * m_k + 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic test_reset();
        en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        reset = 1'b0;
        #12;
        n_checks++; if (clk_out !== 1'b0) $display("FAIL rst_clk_out: got %b want 0", clk_out); else n_pass++;
        n_checks++; if (tick !== 1'b0) $display("FAIL rst_tick: got %b want 0", tick); else n_pass++;
        n_checks++; if (div_active !== 16'd2) $display("FAIL rst_div: got %0d want 2", div_active); else n_pass++;
        n_checks++; if (cfg_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", cfg_ready); else n_pass++;
        n_checks++; if (cfg_err !== 1'b0) $display("FAIL rst_err: got %b want 0", cfg_err); else n_pass++;
        do_reset();
        en = 1'b1;
        step();
        n_checks++; if (a_tick !== 1'b1) $display("FAIL rst_first_wrap_tick: got %b want 1", a_tick); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++; if (a_out_p !== e_out_p) $display("FAIL d2_out_pos: got %b want %b", a_out_p, e_out_p); else n_pass++;
            n_checks++; if (a_out_n !== e_out_n) $display("FAIL d2_out_neg: got %b want %b", a_out_n, e_out_n); else n_pass++;
            n_checks++; if (a_tick !== m_tick) $display("FAIL d2_tick: got %b want %b", a_tick, m_tick); else n_pass++;
            n_checks++; if (a_div !== 16'd2) $display("FAIL d2_div: got %0d want 2", a_div); else n_pass++;
        end
    endtask

    task automatic test_even();
        cfg_valid = 1'b1; cfg_div = 16'd4;
        step();
        cfg_valid = 1'b0;
        n_checks++; if (a_ready !== 1'b0) $display("FAIL d4_ready_low: got %b want 0", a_ready); else n_pass++;
        for (int i = 0; i < 14; i++) begin
            step();
            n_checks++; if (a_ready !== m_ready) $display("FAIL d4_ready: got %b want %b", a_ready, m_ready); else n_pass++;
            n_checks++; if (a_div !== div_t'(m_d)) $display("FAIL d4_div: got %0d want %0d", a_div, m_d); else n_pass++;
            n_checks++; if (a_out_p !== e_out_p) $display("FAIL d4_out_pos: got %b want %b", a_out_p, e_out_p); else n_pass++;
            n_checks++; if (a_out_n !== e_out_n) $display("FAIL d4_out_neg: got %b want %b", a_out_n, e_out_n); else n_pass++;
            n_checks++; if (a_tick !== m_tick) $display("FAIL d4_tick: got %b want %b", a_tick, m_tick); else n_pass++;
        end
        n_checks++; if (a_div !== 16'd4) $display("FAIL d4_final_div: got %0d want 4", a_div); else n_pass++;
    endtask

    task automatic test_odd();
        cfg_valid = 1'b1; cfg_div = 16'd5;
        step();
        cfg_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            n_checks++; if (a_out_p !== e_out_p) $display("FAIL d5_out_pos: got %b want %b", a_out_p, e_out_p); else n_pass++;
            n_checks++; if (a_out_n !== e_out_n) $display("FAIL d5_out_neg: got %b want %b", a_out_n, e_out_n); else n_pass++;
            n_checks++; if (a_tick !== m_tick) $display("FAIL d5_tick: got %b want %b", a_tick, m_tick); else n_pass++;
            n_checks++; if (a_div !== div_t'(m_d)) $display("FAIL d5_div: got %0d want %0d", a_div, m_d); else n_pass++;
        end
        n_checks++; if (t_rise - t_prev_rise !== 50) $display("FAIL d5_period: got %0t want 50", t_rise - t_prev_rise); else n_pass++;
        n_checks++; if (t_high !== 25) $display("FAIL d5_high: got %0t want 25", t_high); else n_pass++;
    endtask

    task automatic test_cfg_err();
        div_t bad [2];
        bad[0] = 16'd0; bad[1] = 16'd1;
        for (int j = 0; j < 2; j++) begin
            cfg_valid = 1'b1; cfg_div = bad[j];
            step();
            cfg_valid = 1'b0;
            n_checks++; if (a_err !== 1'b1) $display("FAIL err_pulse: got %b want 1 (D=%0d)", a_err, bad[j]); else n_pass++;
            n_checks++; if (a_ready !== 1'b1) $display("FAIL err_ready: got %b want 1", a_ready); else n_pass++;
            step();
            n_checks++; if (a_err !== 1'b0) $display("FAIL err_one_cycle: got %b want 0", a_err); else n_pass++;
            n_checks++; if (a_div !== 16'd5) $display("FAIL err_div: got %0d want 5", a_div); else n_pass++;
            n_checks++; if (a_out_p !== e_out_p) $display("FAIL err_out_pos: got %b want %b", a_out_p, e_out_p); else n_pass++;
            n_checks++; if (a_out_n !== e_out_n) $display("FAIL err_out_neg: got %b want %b", a_out_n, e_out_n); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20 && m_k != m_d - 1; i++) step();
        cfg_valid = 1'b1; cfg_div = 16'd6;
        step();
        n_checks++; if (a_ready !== 1'b0) $display("FAIL b2b_accept: got %b want 0", a_ready); else n_pass++;
        n_checks++; if (a_div !== 16'd5) $display("FAIL b2b_not_now: got %0d want 5", a_div); else n_pass++;
        cfg_div = 16'd3;
        repeat (2) begin
            step();
            n_checks++; if (a_err !== 1'b0) $display("FAIL b2b_ignored_err: got %b want 0", a_err); else n_pass++;
        end
        cfg_valid = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            n_checks++; if (a_div !== div_t'(m_d)) $display("FAIL b2b_div: got %0d want %0d", a_div, m_d); else n_pass++;
            n_checks++; if (a_ready !== m_ready) $display("FAIL b2b_ready: got %b want %b", a_ready, m_ready); else n_pass++;
            n_checks++; if (a_out_p !== e_out_p) $display("FAIL b2b_out_pos: got %b want %b", a_out_p, e_out_p); else n_pass++;
            n_checks++; if (a_out_n !== e_out_n) $display("FAIL b2b_out_neg: got %b want %b", a_out_n, e_out_n); else n_pass++;
        end
        n_checks++; if (a_div !== 16'd6) $display("FAIL b2b_final_div: got %0d want 6", a_div); else n_pass++;
    endtask

    task automatic test_enable_and_reset();
        for (int i = 0; i < 20 && m_k != 1; i++) step();
        en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            n_checks++; if (a_out_p !== 1'b1) $display("FAIL hold_out_pos: got %b want 1", a_out_p); else n_pass++;
            n_checks++; if (a_out_n !== 1'b1) $display("FAIL hold_out_neg: got %b want 1", a_out_n); else n_pass++;
            n_checks++; if (a_tick !== 1'b0) $display("FAIL hold_tick: got %b want 0", a_tick); else n_pass++;
        end
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            n_checks++; if (a_out_p !== e_out_p) $display("FAIL resume_out_pos: got %b want %b", a_out_p, e_out_p); else n_pass++;
            n_checks++; if (a_out_n !== e_out_n) $display("FAIL resume_out_neg: got %b want %b", a_out_n, e_out_n); else n_pass++;
            n_checks++; if (a_tick !== m_tick) $display("FAIL resume_tick: got %b want %b", a_tick, m_tick); else n_pass++;
        end
        for (int i = 0; i < 20 && m_k != 1; i++) step();
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        n_checks++; if (clk_out !== 1'b0) $display("FAIL midrst_clk_out: got %b want 0", clk_out); else n_pass++;
        n_checks++; if (tick !== 1'b0) $display("FAIL midrst_tick: got %b want 0", tick); else n_pass++;
        n_checks++; if (div_active !== 16'd2) $display("FAIL midrst_div: got %0d want 2", div_active); else n_pass++;
        n_checks++; if (cfg_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", cfg_ready); else n_pass++;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++; if (a_div !== 16'd2) $display("FAIL postrst_div: got %0d want 2", a_div); else n_pass++;
            n_checks++; if (a_out_p !== e_out_p) $display("FAIL postrst_out_pos: got %b want %b", a_out_p, e_out_p); else n_pass++;
            n_checks++; if (a_tick !== m_tick) $display("FAIL postrst_tick: got %b want %b", a_tick, m_tick); else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            en        = ($urandom % 8) != 0;
            cfg_valid = ($urandom % 6) == 0;
            cfg_div   = div_t'($urandom % 10);
            step();
            n_checks++; if (a_out_p !== e_out_p) $display("FAIL rnd_out_pos: got %b want %b (cyc %0d)", a_out_p, e_out_p, i); else n_pass++;
            n_checks++; if (a_out_n !== e_out_n) $display("FAIL rnd_out_neg: got %b want %b (cyc %0d)", a_out_n, e_out_n, i); else n_pass++;
            n_checks++; if (a_tick !== m_tick) $display("FAIL rnd_tick: got %b want %b (cyc %0d)", a_tick, m_tick, i); else n_pass++;
            n_checks++; if (a_ready !== m_ready) $display("FAIL rnd_ready: got %b want %b (cyc %0d)", a_ready, m_ready, i); else n_pass++;
            n_checks++; if (a_err !== m_err) $display("FAIL rnd_err: got %b want %b (cyc %0d)", a_err, m_err, i); else n_pass++;
            n_checks++; if (a_div !== div_t'(m_d)) $display("FAIL rnd_div: got %0d want %0d (cyc %0d)", a_div, m_d, i); else n_pass++;
        end
        en = 1'b1; cfg_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_even();
        test_odd();
        test_cfg_err();
        test_back_to_back();
        test_enable_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
